keypad_matrix_scanner: RTL and testbench
========================================

// Module: keypad_matrix_scanner
// PURPOSE
// Reader end of the 4x4 matrix keypad used by the quiz/scoring core. Drives one-hot
// column strobes, samples row returns, debounces, and hands one clean key event per
// press (4-bit code + 1-cycle valid) to the mark logic. Sits between board pins and the core.
// PARAMETERS
// SCAN_DIV     16   clocks per column slot (>=4); row sampled in last cycle of slot
// DEBOUNCE_CNT 4    consecutive matching slot samples required to accept press/release (>=1)
// REPEAT_CYC   5000 clocks between auto-repeat events (used only with KEY_REPEAT_EN)
// PORTS
// clk        in   1  system clock
// rst        in   1  asynchronous, active-low reset
// row        in   4  keypad row returns, active-high, asynchronous to clk
// col        out  4  column strobe, one-hot active-high
// key_code   out  4  code of accepted key = row_idx*4 + col_idx (idx = bit position)
// key_valid  out  1  one-cycle pulse when key_code is newly accepted
// key_held   out  1  high from acceptance until release is debounced
// BEHAVIOUR
// - Reset (rst=0, async): col=4'b0001, key_code=0, key_valid=0, key_held=0, state SCAN,
//   slot/debounce counters 0, synchroniser flops 0. Reset mid-press discards the press.
// - row passes a 2-flop synchroniser; all decisions use synchronised value rs.
// - Slot counter counts 0..SCAN_DIV-1 in every state; "sample" = cycle where count==SCAN_DIV-1.
// - Valid hit: rs has exactly one bit set. rs==0 = no key; >1 bit set = ghost, treated as no key.
// - FSM:
//   SCAN:     on sample with valid hit: latch rs and col, deb=1, -> DEBOUNCE (col frozen);
//             else rotate col left (0001->0010->0100->1000->0001) at end of slot.
//   DEBOUNCE: on sample: rs==latched -> deb++; deb reaching DEBOUNCE_CNT -> load key_code,
//             pulse key_valid next cycle, key_held=1, deb=0, -> HELD.
//             rs!=latched -> deb=0, rotate col, -> SCAN (no event).
//             DEBOUNCE_CNT=1: acceptance on the first sample, DEBOUNCE transited in 1 cycle.
//   HELD:     col frozen. on sample: rs==0 -> deb++; else deb=0. deb reaching
//             DEBOUNCE_CNT -> key_held=0, deb=0, rotate col, -> SCAN.
//             A second key pressed while held is ignored (no event) until full release.
// - key_valid is exactly 1 cycle, registered; key_code changes only in that same cycle
//   and holds its value otherwise (including after release).
// - Latency: key_valid asserts 1 clk after the DEBOUNCE_CNT-th matching sample,
//   i.e. (DEBOUNCE_CNT-1)*SCAN_DIV + 1 clks after the first detecting sample.
// - Counters sized $clog2 of their limits; no wrap beyond limits (saturating/reset at target).
// CONFIGURATION
// KEY_REPEAT_EN defined: in HELD, a repeat counter runs while key remains pressed; every
//   REPEAT_CYC clks after acceptance it re-pulses key_valid (same key_code); counter cleared
//   on release start (any sample with rs==0) and on reset.
// KEY_REPEAT_EN undefined: exactly one key_valid per press; no repeat counter synthesised.
// TESTING (bench uses SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_CYC=40)
// 1 reset: rst=0 mid-scan -> col=0001, key_valid=0, key_held=0, key_code=0 immediately.
// 2 hold row=4'b0010 while col==0100 (model keypad) -> single key_valid, key_code=6,
//   key_held=1, col frozen at 0100; release -> key_held=0 after 3 zero samples, scan resumes.
// 3 bounce: row toggles every 2 clks for 20 clks then steady 4'b0001 at col 0001 ->
//   exactly one key_valid, key_code=0; no event during bounce.
// 4 ghost: row=4'b0011 at any col -> no key_valid, col keeps rotating.
// 5 held + second key: hold key 6, add key 15 -> no new event; release all -> one event total.
// 6 KEY_REPEAT_EN: hold key 9 for 130 clks after acceptance -> key_valid at +0,+40,+80,+120,
//   key_code=9 each; without macro -> exactly one pulse.

Source files
------------

// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_matrix_scanner
//  Purpose  : 4x4 matrix keypad reader. Strobes columns, synchronises and
//             debounces row returns, emits one key event per press.
//  Options  : KEY_REPEAT_EN - auto-repeat key_valid every REPEAT_CYC clocks
//             while a key stays held.
//  Revision : 1.0
// ============================================================================
module keypad_matrix_scanner #(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 4,
    parameter int REPEAT_CYC   = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int DEB_W  = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE   = SLOT_W'(1);
    localparam logic [DEB_W-1:0]  DEB_TARGET = DEB_W'(DEBOUNCE_CNT);
    localparam logic [DEB_W-1:0]  DEB_ONE    = DEB_W'(1);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;

    logic [3:0]        row_meta;
    logic [3:0]        rs;
    logic [SLOT_W-1:0] slot;
    logic [DEB_W-1:0]  deb;
    logic [1:0]        state;
    logic [3:0]        lat_row;

    logic              sample;
    logic              hit;
    logic              match;
    logic              rs_zero;
    logic [3:0]        col_rot;
    logic [DEB_W-1:0]  deb_inc;
    logic              rep_fire;

    function automatic logic [1:0] idx4(input logic [3:0] onehot);
        case (onehot)
            4'b0010: idx4 = 2'd1;
            4'b0100: idx4 = 2'd2;
            4'b1000: idx4 = 2'd3;
            default: idx4 = 2'd0;
        endcase
    endfunction

    assign sample  = (slot == SLOT_LAST);
    // Exactly one row asserted; multiple rows are ghosting and count as no key.
    assign hit     = (rs != 4'd0) && ((rs & (rs - 4'd1)) == 4'd0);
    assign match   = (rs == lat_row);
    assign rs_zero = (rs == 4'd0);
    assign col_rot = {col[2:0], col[3]};
    assign deb_inc = deb + DEB_ONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta <= 4'd0;
            rs       <= 4'd0;
        end else begin
            row_meta <= row;
            rs       <= row_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot <= '0;
        end else if (sample) begin
            slot <= '0;
        end else begin
            slot <= slot + SLOT_ONE;
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int REP_W = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYC - 1);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

    logic [REP_W-1:0] rep;

    // Counts clocks since acceptance; any zero-row sample restarts it.
    assign rep_fire = key_held && (rep == REP_LAST) && !(sample && rs_zero);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep <= '0;
        end else if (!key_held || (sample && rs_zero)) begin
            rep <= '0;
        end else if (rep == REP_LAST) begin
            rep <= '0;
        end else begin
            rep <= rep + REP_ONE;
        end
    end
`else
    assign rep_fire = 1'b0 & (REPEAT_CYC > 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_SCAN;
            col       <= 4'b0001;
            deb       <= '0;
            lat_row   <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= rep_fire;
            case (state)
                ST_SCAN: begin
                    if (sample) begin
                        if (hit) begin
                            lat_row <= rs;
                            state   <= ST_DEBOUNCE;
                            if (DEBOUNCE_CNT == 1) begin
                                key_code  <= {idx4(rs), idx4(col)};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                deb       <= '0;
                            end else begin
                                deb <= DEB_ONE;
                            end
                        end else begin
                            col <= col_rot;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    // With a single-sample debounce the key was already accepted on entry.
                    if (DEBOUNCE_CNT == 1) begin
                        state <= ST_HELD;
                    end else if (sample) begin
                        if (match) begin
                            if (deb_inc == DEB_TARGET) begin
                                key_code  <= {idx4(lat_row), idx4(col)};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                deb       <= '0;
                                state     <= ST_HELD;
                            end else begin
                                deb <= deb_inc;
                            end
                        end else begin
                            deb   <= '0;
                            col   <= col_rot;
                            state <= ST_SCAN;
                        end
                    end
                end
                ST_HELD: begin
                    if (sample) begin
                        if (rs_zero) begin
                            if (deb_inc == DEB_TARGET) begin
                                key_held <= 1'b0;
                                deb      <= '0;
                                col      <= col_rot;
                                state    <= ST_SCAN;
                            end else begin
                                deb <= deb_inc;
                            end
                        end else begin
                            deb <= '0;
                        end
                    end
                end
                default: begin
                    state <= ST_SCAN;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_matrix_scanner
//  Purpose  : Directed bench for keypad_matrix_scanner with a keypad model.
//  Revision : 1.0
// ============================================================================
module tb_keypad_matrix_scanner;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] keys;
    logic        use_raw;
    logic [3:0]  raw_row;
    logic [3:0]  mrow;

    int total = 0;
    int bad   = 0;

    keypad_matrix_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3),
        .REPEAT_CYC   (40)
    ) dut (
        .clk       (clk),
        .rst       (rst_n),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key k sits at row k/4, column k%4 and closes that row when its column is strobed.
    always_comb begin
        mrow = 4'd0;
        for (int r = 0; r < 4; r++) begin
            mrow[r] = |(keys[r*4 +: 4] & col);
        end
        row = use_raw ? raw_row : mrow;
    end

    task automatic tick(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (key_valid) pulses++;
        end
    endtask

    task automatic wait_valid(input int bound, output int waited, output bit ok);
        ok = 1'b0;
        waited = 0;
        while (!ok && waited < bound) begin
            @(negedge clk);
            waited++;
            if (key_valid) ok = 1'b1;
        end
    endtask

    task automatic wait_held_low(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (!key_held) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        int p;
        rst_n = 1'b0; keys = 16'h0; use_raw = 1'b0; raw_row = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick(6, p);
        total++;
        if (col !== 4'b0010) begin bad++; $display("FAIL scan_before_reset: col=%b want 0010", col); end
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (col !== 4'b0001) begin bad++; $display("FAIL reset_col: col=%b want 0001", col); end
        total++;
        if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", key_valid); end
        total++;
        if (key_held !== 1'b0) begin bad++; $display("FAIL reset_held: got %b want 0", key_held); end
        total++;
        if (key_code !== 4'd0) begin bad++; $display("FAIL reset_code: got %0d want 0", key_code); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_press;
        int  p, waited;
        bit  ok, found;
        keys = 16'h0040;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (col == 4'b0100) found = 1'b1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL press_reach_col: col=%b want 0100", col); end
        wait_valid(40, waited, ok);
        total++;
        if (!ok || waited != 12) begin bad++; $display("FAIL press_latency: got %0d (seen=%0d) want 12", waited, ok); end
        total++;
        if (key_code !== 4'd6) begin bad++; $display("FAIL press_code: got %0d want 6", key_code); end
        total++;
        if (key_held !== 1'b1) begin bad++; $display("FAIL press_held: got %b want 1", key_held); end
        @(negedge clk);
        total++;
        if (key_valid !== 1'b0) begin bad++; $display("FAIL press_pulse_width: got %b want 0", key_valid); end
        tick(30, p);
        total++;
        if (p != 0) begin bad++; $display("FAIL press_single: extra pulses=%0d want 0", p); end
        total++;
        if (col !== 4'b0100) begin bad++; $display("FAIL press_col_frozen: col=%b want 0100", col); end
        keys = 16'h0;
        wait_held_low(60, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL release_timeout: key_held=%b want 0", key_held); end
        total++;
        if (col !== 4'b1000) begin bad++; $display("FAIL release_col: col=%b want 1000", col); end
        total++;
        if (key_code !== 4'd6) begin bad++; $display("FAIL release_code_hold: got %0d want 6", key_code); end
        tick(4, p);
        total++;
        if (col !== 4'b0001) begin bad++; $display("FAIL scan_resume: col=%b want 0001", col); end
    endtask

    task automatic test_reset_mid_press;
        int p, waited;
        bit ok;
        keys = 16'h0040;
        wait_valid(60, waited, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL midrst_accept: timeout after %0d clks", waited); end
        tick(2, p);
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (key_held !== 1'b0) begin bad++; $display("FAIL midrst_held: got %b want 0", key_held); end
        total++;
        if (key_code !== 4'd0) begin bad++; $display("FAIL midrst_code: got %0d want 0", key_code); end
        total++;
        if (col !== 4'b0001) begin bad++; $display("FAIL midrst_col: col=%b want 0001", col); end
        keys = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(40, p);
        total++;
        if (p != 0) begin bad++; $display("FAIL midrst_no_event: pulses=%0d want 0", p); end
    endtask

    task automatic test_bounce;
        int         p, waited;
        bit         ok, found;
        logic [3:0] prev;
        found = 1'b0;
        prev  = col;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (col == 4'b0001 && prev == 4'b1000) found = 1'b1;
            prev = col;
        end
        total++;
        if (!found) begin bad++; $display("FAIL bounce_sync: col=%b want 0001", col); end
        p = 0;
        for (int i = 0; i < 20; i++) begin
            keys = ((i % 4) >= 2) ? 16'h0001 : 16'h0000;
            @(negedge clk);
            if (key_valid) p++;
        end
        keys = 16'h0001;
        total++;
        if (p != 0) begin bad++; $display("FAIL bounce_quiet: pulses=%0d want 0", p); end
        wait_valid(60, waited, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bounce_accept: timeout after %0d clks", waited); end
        total++;
        if (key_code !== 4'd0) begin bad++; $display("FAIL bounce_code: got %0d want 0", key_code); end
        tick(20, p);
        total++;
        if (p != 0) begin bad++; $display("FAIL bounce_single: extra pulses=%0d want 0", p); end
        keys = 16'h0;
        wait_held_low(60, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bounce_release: key_held=%b want 0", key_held); end
    endtask

    task automatic test_ghost;
        int         p, changes;
        logic [3:0] prev;
        use_raw = 1'b1;
        raw_row = 4'b0011;
        p = 0; changes = 0;
        prev = col;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (key_valid) p++;
            if (col != prev) changes++;
            prev = col;
        end
        total++;
        if (p != 0) begin bad++; $display("FAIL ghost_no_event: pulses=%0d want 0", p); end
        total++;
        if (changes != 10) begin bad++; $display("FAIL ghost_rotate: col changes=%0d want 10", changes); end
        total++;
        if (key_held !== 1'b0) begin bad++; $display("FAIL ghost_held: got %b want 0", key_held); end
        use_raw = 1'b0;
        raw_row = 4'd0;
        tick(8, p);
    endtask

    task automatic test_held_second;
        int p, waited;
        bit ok;
        keys = 16'h0040;
        wait_valid(60, waited, ok);
        total++;
        if (!ok || key_code !== 4'd6) begin bad++; $display("FAIL held2_first: seen=%0d code=%0d want 6", ok, key_code); end
        keys = 16'h8040;
        tick(30, p);
        total++;
        if (p != 0) begin bad++; $display("FAIL held2_ignored: pulses=%0d want 0", p); end
        total++;
        if (col !== 4'b0100) begin bad++; $display("FAIL held2_col: col=%b want 0100", col); end
        keys = 16'h0;
        wait_held_low(60, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL held2_release: key_held=%b want 0", key_held); end
        tick(30, p);
        total++;
        if (p != 0) begin bad++; $display("FAIL held2_after: pulses=%0d want 0", p); end
    endtask

    task automatic test_repeat;
        int p, waited, n;
        int at [0:3];
        bit ok;
        keys = 16'h0200;
        wait_valid(60, waited, ok);
        total++;
        if (!ok || key_code !== 4'd9) begin bad++; $display("FAIL repeat_first: seen=%0d code=%0d want 9", ok, key_code); end
        n = 0;
        for (int k = 1; k <= 130; k++) begin
            @(negedge clk);
            if (key_valid) begin
                if (n < 4) at[n] = k;
                n++;
                total++;
                if (key_code !== 4'd9) begin bad++; $display("FAIL repeat_code: got %0d want 9 at +%0d", key_code, k); end
            end
        end
`ifdef KEY_REPEAT_EN
        total++;
        if (n != 3) begin bad++; $display("FAIL repeat_count: got %0d want 3", n); end
        for (int j = 0; j < 3; j++) begin
            total++;
            if (n > j && at[j] != 40 * (j + 1)) begin bad++; $display("FAIL repeat_time: pulse %0d at +%0d want +%0d", j, at[j], 40 * (j + 1)); end
        end
`else
        total++;
        if (n != 0) begin bad++; $display("FAIL repeat_none: got %0d extra pulses want 0 (first at +%0d)", n, at[0]); end
`endif
        keys = 16'h0;
        wait_held_low(60, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL repeat_release: key_held=%b want 0", key_held); end
        tick(8, p);
    endtask

    initial begin
        test_reset();
        test_press();
        test_reset_mid_press();
        test_bounce();
        test_ghost();
        test_held_second();
        test_repeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
